// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit port bundle: decoded ID-stage fields in, pipeline controls and counters out.
// master = decode/datapath side, slave = hazard unit.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              branch_taken;

    logic              pc_en;
    logic              ifid_en;
    logic              flush_ifid;
    logic              flush_idex;
    logic              flush_exmem;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_reg_write, id_mem_read, branch_taken,
        input  pc_en, ifid_en, flush_ifid, flush_idex, flush_exmem, stall,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_reg_write, id_mem_read, branch_taken,
        output pc_en, ifid_en, flush_ifid, flush_idex, flush_exmem, stall,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding control for a 5-stage pipeline; controls are combinational, counters lag one edge.
// Backpressure: a RAW/load-use stall drops pc_en/ifid_en and injects an ID/EX bubble; a taken branch overrides it.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 1,
    parameter int BR_STAGE  = 2,
    parameter int CNT_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef logic [REG_AW-1:0] reg_t;
    typedef struct packed {
        logic v;
        reg_t dst;
        logic wr;
    } dst_t;
    typedef struct packed {
        reg_t rs;
        reg_t rt;
        logic use_rs;
        logic use_rt;
    } src_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             BR_IN_MEM = (BR_STAGE == 3);
    localparam logic             USE_FWD   = (FWD_EN != 0);
    localparam logic             WB_HAZ    = (RF_BYPASS == 0);

    dst_t             ex_dst, mem_dst, wb_dst;
    logic             ex_mrd;
    src_t             ex_src;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hit_ex, hit_mem, hit_wb, raw_haz, stall_c, squash_id;

    // Register 0 is hard-wired, so it can never be the subject of a hazard.
    function automatic logic writes(dst_t s, reg_t r);
        return s.v && s.wr && (s.dst == r) && (r != '0);
    endfunction

    function automatic logic reads_from(dst_t s, logic use_rs, reg_t rs, logic use_rt, reg_t rt);
        return (use_rs && writes(s, rs)) || (use_rt && writes(s, rt));
    endfunction

    function automatic logic [1:0] fwd_sel(logic use_src, reg_t src, dst_t m, dst_t w);
        if (use_src && writes(m, src)) return 2'd1;
        if (use_src && writes(w, src)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        hit_ex  = reads_from(ex_dst,  hz.id_use_rs, hz.id_rs, hz.id_use_rt, hz.id_rt);
        hit_mem = reads_from(mem_dst, hz.id_use_rs, hz.id_rs, hz.id_use_rt, hz.id_rt);
        hit_wb  = reads_from(wb_dst,  hz.id_use_rs, hz.id_rs, hz.id_use_rt, hz.id_rt);
        if (USE_FWD) raw_haz = hz.id_valid && hit_ex && ex_mrd;
        else         raw_haz = hz.id_valid && (hit_ex || hit_mem || (WB_HAZ && hit_wb));
        stall_c   = raw_haz && !hz.branch_taken;
        squash_id = stall_c || hz.branch_taken || !hz.id_valid;
    end

    assign hz.stall       = stall_c;
    assign hz.pc_en       = !stall_c;
    assign hz.ifid_en     = !stall_c;
    assign hz.flush_ifid  = hz.branch_taken;
    assign hz.flush_idex  = hz.branch_taken;
    assign hz.flush_exmem = BR_IN_MEM && hz.branch_taken;
    assign hz.fwd_a       = USE_FWD ? fwd_sel(ex_src.use_rs, ex_src.rs, mem_dst, wb_dst) : 2'd0;
    assign hz.fwd_b       = USE_FWD ? fwd_sel(ex_src.use_rt, ex_src.rt, mem_dst, wb_dst) : 2'd0;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_dst      <= '0;
            mem_dst     <= '0;
            wb_dst      <= '0;
            ex_mrd      <= 1'b0;
            ex_src      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_dst  <= mem_dst;
            // A MEM-resolved branch also kills the instruction leaving EX.
            mem_dst <= (BR_IN_MEM && hz.branch_taken) ? '0 : ex_dst;
            if (squash_id) begin
                ex_dst <= '0;
                ex_mrd <= 1'b0;
                ex_src <= '0;
            end else begin
                ex_dst <= '{v: 1'b1, dst: hz.id_dst, wr: hz.id_reg_write};
                ex_mrd <= hz.id_mem_read;
                ex_src <= '{rs: hz.id_rs, rt: hz.id_rt, use_rs: hz.id_use_rs, use_rt: hz.id_use_rt};
            end
            if (stall_c && stall_cnt_q != CNT_MAX)         stall_cnt_q <= stall_cnt_q + 1'b1;
            if (hz.branch_taken && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives three hazard-unit configurations (A: fwd/bypass/MEM branch, B: stall-only no bypass,
// C: stall-only bypass with 2-bit counters) from one stimulus stream and checks them against a history model.
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic        stall, pc_en, ifid_en, fl_ifid, fl_idex, fl_exmem;
        logic [1:0]  fwd_a, fwd_b;
        logic [15:0] stall_cnt, flush_cnt;
    } obs_t;
    typedef struct {
        bit v;
        int dst, rs, rt;
        bit wr, mrd, urs, urt;
    } rec_t;
    localparam int HIST = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, id_dst;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifb ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  ifc ();

    assign ifa.id_valid = id_valid;   assign ifb.id_valid = id_valid;   assign ifc.id_valid = id_valid;
    assign ifa.id_rs = id_rs;         assign ifb.id_rs = id_rs;         assign ifc.id_rs = id_rs;
    assign ifa.id_rt = id_rt;         assign ifb.id_rt = id_rt;         assign ifc.id_rt = id_rt;
    assign ifa.id_use_rs = id_use_rs; assign ifb.id_use_rs = id_use_rs; assign ifc.id_use_rs = id_use_rs;
    assign ifa.id_use_rt = id_use_rt; assign ifb.id_use_rt = id_use_rt; assign ifc.id_use_rt = id_use_rt;
    assign ifa.id_dst = id_dst;       assign ifb.id_dst = id_dst;       assign ifc.id_dst = id_dst;
    assign ifa.id_reg_write = id_reg_write; assign ifb.id_reg_write = id_reg_write; assign ifc.id_reg_write = id_reg_write;
    assign ifa.id_mem_read = id_mem_read;   assign ifb.id_mem_read = id_mem_read;   assign ifc.id_mem_read = id_mem_read;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken; assign ifc.branch_taken = branch_taken;

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .RF_BYPASS(1), .BR_STAGE(3), .CNT_W(16))
        dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .RF_BYPASS(0), .BR_STAGE(2), .CNT_W(16))
        dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));
    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .RF_BYPASS(1), .BR_STAGE(2), .CNT_W(2))
        dut_c (.clk(clk), .rst_n(rst_n), .hz(ifc.slave));

    obs_t obs [3];
    obs_t last [3];
    assign obs[0] = {ifa.stall, ifa.pc_en, ifa.ifid_en, ifa.flush_ifid, ifa.flush_idex, ifa.flush_exmem,
                     ifa.fwd_a, ifa.fwd_b, ifa.stall_cnt, ifa.flush_cnt};
    assign obs[1] = {ifb.stall, ifb.pc_en, ifb.ifid_en, ifb.flush_ifid, ifb.flush_idex, ifb.flush_exmem,
                     ifb.fwd_a, ifb.fwd_b, ifb.stall_cnt, ifb.flush_cnt};
    assign obs[2] = {ifc.stall, ifc.pc_en, ifc.ifid_en, ifc.flush_ifid, ifc.flush_idex, ifc.flush_exmem,
                     ifc.fwd_a, ifc.fwd_b, 14'd0, ifc.stall_cnt, 14'd0, ifc.flush_cnt};

    // Model: hist[m][hn-1] is what sits in EX, hn-2 in MEM, hn-3 in WB.
    rec_t hist [3][HIST];
    int   hn [3];
    int   m_sc [3];
    int   m_fc [3];
    int   total = 0;
    int   passed = 0;

    function automatic bit cfg_fwd(int m); return m == 0; endfunction
    function automatic bit cfg_byp(int m); return m != 1; endfunction
    function automatic bit cfg_br3(int m); return m == 0; endfunction
    function automatic int cfg_max(int m); return (m == 2) ? 3 : 65535; endfunction
    function automatic string dname(int m); return (m == 0) ? "A" : (m == 1) ? "B" : "C"; endfunction

    function automatic rec_t no_instr();
        rec_t r = '{default: 0};
        return r;
    endfunction

    function automatic rec_t id_rec();
        rec_t r;
        r.v = id_valid; r.dst = int'(id_dst); r.rs = int'(id_rs); r.rt = int'(id_rt);
        r.wr = id_reg_write; r.mrd = id_mem_read; r.urs = id_use_rs; r.urt = id_use_rt;
        return r;
    endfunction

    function automatic bit produces(rec_t p, int r);
        return p.v && p.wr && p.dst == r && r != 0;
    endfunction

    function automatic bit m_stall(int m);
        rec_t idr = id_rec();
        bit   s = 0;
        if (!idr.v || branch_taken) return 0;
        for (int age = 1; age <= 3; age++) begin
            rec_t p = hist[m][hn[m] - age];
            bit dep = (idr.urs && produces(p, idr.rs)) || (idr.urt && produces(p, idr.rt));
            if (cfg_fwd(m)) s |= dep && age == 1 && p.mrd;
            else            s |= dep && (age <= 2 || !cfg_byp(m));
        end
        return s;
    endfunction

    function automatic int m_fwd(int m, bit use_rt);
        rec_t e = hist[m][hn[m] - 1];
        int   src = use_rt ? e.rt : e.rs;
        bit   u = use_rt ? e.urt : e.urs;
        if (!cfg_fwd(m) || !e.v || !u) return 0;
        for (int age = 2; age <= 3; age++)
            if (produces(hist[m][hn[m] - age], src)) return age - 1;
        return 0;
    endfunction

    function automatic obs_t m_exp(int m);
        obs_t o;
        bit s = m_stall(m);
        o.stall = s; o.pc_en = !s; o.ifid_en = !s;
        o.fl_ifid = branch_taken; o.fl_idex = branch_taken; o.fl_exmem = branch_taken && cfg_br3(m);
        o.fwd_a = 2'(m_fwd(m, 0)); o.fwd_b = 2'(m_fwd(m, 1));
        o.stall_cnt = 16'(m_sc[m]); o.flush_cnt = 16'(m_fc[m]);
        return o;
    endfunction

    task automatic model_edge();
        for (int m = 0; m < 3; m++) begin
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) hist[m][k] = no_instr();
                hn[m] = 3; m_sc[m] = 0; m_fc[m] = 0;
            end else begin
                bit s;
                s = m_stall(m);
                if (s && m_sc[m] < cfg_max(m)) m_sc[m]++;
                if (branch_taken && m_fc[m] < cfg_max(m)) m_fc[m]++;
                if (branch_taken && cfg_br3(m)) hist[m][hn[m] - 1].v = 0;
                if (hn[m] == HIST) begin
                    for (int k = 0; k < 3; k++) hist[m][k] = hist[m][HIST - 3 + k];
                    hn[m] = 3;
                end
                hist[m][hn[m]] = (s || branch_taken || !id_valid) ? no_instr() : id_rec();
                hn[m]++;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    endtask

    task automatic compare(int m);
        obs_t  e = m_exp(m);
        obs_t  o = obs[m];
        string t = dname(m);
        chk({t, ".stall"},     32'(o.stall),     32'(e.stall));
        chk({t, ".pc_en"},     32'(o.pc_en),     32'(e.pc_en));
        chk({t, ".ifid_en"},   32'(o.ifid_en),   32'(e.ifid_en));
        chk({t, ".fl_ifid"},   32'(o.fl_ifid),   32'(e.fl_ifid));
        chk({t, ".fl_idex"},   32'(o.fl_idex),   32'(e.fl_idex));
        chk({t, ".fl_exmem"},  32'(o.fl_exmem),  32'(e.fl_exmem));
        chk({t, ".fwd_a"},     32'(o.fwd_a),     32'(e.fwd_a));
        chk({t, ".fwd_b"},     32'(o.fwd_b),     32'(e.fwd_b));
        chk({t, ".stall_cnt"}, 32'(o.stall_cnt), 32'(e.stall_cnt));
        chk({t, ".flush_cnt"}, 32'(o.flush_cnt), 32'(e.flush_cnt));
    endtask

    // One clock: settle, check all DUTs against the model, advance model and DUT together.
    task automatic cycle(bit do_chk = 1);
        #1;
        if (do_chk) for (int m = 0; m < 3; m++) compare(m);
        for (int m = 0; m < 3; m++) last[m] = obs[m];
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(bit v, int dst, int rs, int rt, bit urs, bit urt, bit wr, bit mrd, bit br = 0);
        id_valid = v; id_dst = 5'(dst); id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_reg_write = wr; id_mem_read = mrd; branch_taken = br;
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; nop(); cycle();
        rst_n = 1'b1; cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < 3; j++) hist[m][j] = no_instr();
            hn[m] = 3; m_sc[m] = 0; m_fc[m] = 0;
        end

        // Reset held two cycles, then idle outputs.
        rst_n = 1'b0; nop(); cycle(0); cycle();
        rst_n = 1'b1; #1;
        for (int m = 0; m < 3; m++) begin
            chk({dname(m), ".rst_pc_en"},     32'(obs[m].pc_en),     32'd1);
            chk({dname(m), ".rst_stall"},     32'(obs[m].stall),     32'd0);
            chk({dname(m), ".rst_fwd_a"},     32'(obs[m].fwd_a),     32'd0);
            chk({dname(m), ".rst_fwd_b"},     32'(obs[m].fwd_b),     32'd0);
            chk({dname(m), ".rst_stall_cnt"}, 32'(obs[m].stall_cnt), 32'd0);
            chk({dname(m), ".rst_flush_cnt"}, 32'(obs[m].flush_cnt), 32'd0);
        end
        cycle();

        // A: lw $8 ; add $9,$8,$10 -> one stall, then forwarded from MEM/WB.
        ins(1, 8, 1, 0, 1, 0, 1, 1); cycle();
        ins(1, 9, 8, 10, 1, 1, 1, 0); #1 chk("A.loaduse_stall", 32'(obs[0].stall), 32'd1); cycle();
        #1 chk("A.loaduse_release", 32'(obs[0].stall), 32'd0); cycle();
        nop(); #1;
        chk("A.loaduse_fwd_a", 32'(obs[0].fwd_a), 32'd2);
        chk("A.loaduse_cnt", 32'(obs[0].stall_cnt), 32'd1);
        cycle(); cycle(); cycle();

        // A: add $8 ; sub $3,$8,$8 at distance 1, 2, and with $0 destination.
        ins(1, 8, 1, 2, 1, 1, 1, 0); cycle();
        ins(1, 3, 8, 8, 1, 1, 1, 0); #1 chk("A.alu_nostall", 32'(obs[0].stall), 32'd0); cycle();
        nop(); #1;
        chk("A.d1_fwd_a", 32'(obs[0].fwd_a), 32'd1);
        chk("A.d1_fwd_b", 32'(obs[0].fwd_b), 32'd1);
        cycle();
        ins(1, 8, 1, 2, 1, 1, 1, 0); cycle();
        ins(1, 5, 6, 7, 1, 1, 1, 0); cycle();
        ins(1, 3, 8, 8, 1, 1, 1, 0); cycle();
        nop(); #1;
        chk("A.d2_fwd_a", 32'(obs[0].fwd_a), 32'd2);
        chk("A.d2_fwd_b", 32'(obs[0].fwd_b), 32'd2);
        cycle();
        ins(1, 0, 1, 2, 1, 1, 1, 0); cycle();
        ins(1, 3, 0, 0, 1, 1, 1, 0); cycle();
        nop(); #1;
        chk("A.r0_fwd_a", 32'(obs[0].fwd_a), 32'd0);
        chk("A.r0_fwd_b", 32'(obs[0].fwd_b), 32'd0);
        cycle();

        // B: add $8 ; or $4,$8,$5 -> three stall cycles with WB counted.
        do_reset();
        ins(1, 8, 1, 2, 1, 1, 1, 0); cycle();
        ins(1, 4, 8, 5, 1, 1, 1, 0);
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("B.raw_stall", 32'(obs[1].stall), 32'(j < 3));
            chk("B.raw_pc_en", 32'(obs[1].pc_en), 32'(j == 3));
            cycle();
        end
        nop(); #1 chk("B.raw_cnt", 32'(obs[1].stall_cnt), 32'd3); cycle();

        // A (MEM branch): taken branch during a pending load-use stall.
        do_reset();
        ins(1, 8, 1, 0, 1, 0, 1, 1); cycle();
        ins(1, 9, 8, 10, 1, 1, 1, 0, 1); #1;
        chk("A.br_fl_ifid",  32'(obs[0].fl_ifid),  32'd1);
        chk("A.br_fl_idex",  32'(obs[0].fl_idex),  32'd1);
        chk("A.br_fl_exmem", 32'(obs[0].fl_exmem), 32'd1);
        chk("A.br_stall",    32'(obs[0].stall),    32'd0);
        chk("A.br_pc_en",    32'(obs[0].pc_en),    32'd1);
        chk("B.br_fl_exmem", 32'(obs[1].fl_exmem), 32'd0);
        cycle();
        ins(1, 7, 9, 0, 1, 0, 1, 0); #1;
        chk("A.br_flush_cnt", 32'(obs[0].flush_cnt), 32'd1);
        chk("A.br_stall_cnt", 32'(obs[0].stall_cnt), 32'd0);
        chk("B.br_ex_bubble", 32'(obs[1].stall),     32'd0);
        cycle();

        // C (2-bit counters): stall_cnt saturates at 3.
        do_reset();
        k = 0;
        repeat (3) begin
            ins(1, 8, 1, 2, 1, 1, 1, 0); cycle();
            ins(1, 4, 8, 5, 1, 1, 1, 0);
            repeat (3) begin
                cycle();
                if (last[2].stall === 1'b1) begin
                    chk("C.sat_stall_cnt", 32'(obs[2].stall_cnt), 32'(k < 3 ? k + 1 : 3));
                    k++;
                end
            end
        end
        chk("C.stall_events", 32'(k), 32'd6);

        // B: reset asserted while a stall is active.
        nop(); cycle(); cycle(); cycle();
        ins(1, 8, 1, 2, 1, 1, 1, 0); cycle();
        ins(1, 4, 8, 5, 1, 1, 1, 0); #1 chk("B.pre_rst_stall", 32'(obs[1].stall), 32'd1);
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; #1;
        chk("B.post_rst_stall", 32'(obs[1].stall),     32'd0);
        chk("B.post_rst_cnt",   32'(obs[1].stall_cnt), 32'd0);
        cycle();

        // Random traffic on a small register set to provoke every hazard path.
        repeat (1500) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_dst       = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_mem_read  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
